// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional performance counters in fetch_unit are enabled with `define FETCH_PERF_EN.
package fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;

    localparam logic [ADDR_W-1:0]  RESET_PC_DEFAULT = 32'hBFC00000;
    localparam logic [INSTR_W-1:0] NOP              = 32'h00000013;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Registered FIFO of fetched {pc, instr} entries with synchronous clear.
// Clear wins over push and pop in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  fetch_entry_t     push_data_i,
    input  logic             pop_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full || do_pop);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '{pc: '0, instr: NOP};
            end
        end else if (do_push && !clear_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited in-order imem reads, buffered output to decode.
// `define FETCH_PERF_EN adds saturating fetched/flushed event counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned          INSTR_WIDTH = INSTR_W,
    parameter int unsigned          ADDR_WIDTH  = ADDR_W,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned          FIFO_DEPTH  = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic                   imem_req_o,
    output logic [ADDR_WIDTH-1:0]  imem_addr_o,
    input  logic                   imem_gnt_i,
    input  logic                   imem_rvalid_i,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
    input  logic                   pcsrc_i,
    input  logic [ADDR_WIDTH-1:0]  pc_target_i,
    output logic                   instr_valid_o,
    input  logic                   instr_ready_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0]  pc_o,
    output logic [1:0]             state_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]            perf_fetched_o,
    output logic [31:0]            perf_flushed_o
`endif
);

    // Handshakes: a transfer happens in a cycle where valid (req) and ready (gnt) are both
    // high at the rising edge; the producer holds valid and its payload until that transfer.

    localparam logic [1:0] ST_BOOT  = BOOT;
    localparam logic [1:0] ST_FETCH = FETCH;
    localparam logic [1:0] ST_DRAIN = DRAIN;

    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SUM_W  = CNT_W + 1;
    localparam int unsigned DISC_W = 16;
    localparam logic [SUM_W-1:0] DEPTH_C = SUM_W'(FIFO_DEPTH);

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] rsp_pc_q;
    logic [ADDR_WIDTH-1:0] target_aligned;
    logic [CNT_W-1:0]      outstanding_q;
    logic [DISC_W-1:0]     discard_q;
    logic [DISC_W-1:0]     discard_redirect;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_empty;
    logic                  credit_ok;
    logic                  req_fire;
    logic                  rsp_keep;
    logic                  rsp_drop;
    logic                  pop_fire;
    fetch_entry_t          push_entry;
    fetch_entry_t          head_entry;
    fetch_entry_t          held_q;

    // outstanding_q counts only live (non-discarded) reads, so a redirect can request at once.
    assign credit_ok   = ({1'b0, fifo_count} + {1'b0, outstanding_q}) < DEPTH_C;
    assign imem_req_o  = (state_q != ST_BOOT) && credit_ok;
    assign imem_addr_o = pc_q;
    assign req_fire    = imem_req_o && imem_gnt_i;
    assign rsp_drop    = imem_rvalid_i && (discard_q != '0);
    assign rsp_keep    = imem_rvalid_i && (discard_q == '0);
    assign pop_fire    = instr_valid_o && instr_ready_i && !pcsrc_i;
    assign state_o     = state_q;

    assign target_aligned   = {pc_target_i[ADDR_WIDTH-1:2], 2'b00};
    assign discard_redirect = discard_q + DISC_W'(outstanding_q) + DISC_W'(req_fire)
                              - DISC_W'(imem_rvalid_i);

    assign push_entry = '{pc: rsp_pc_q, instr: imem_rdata_i};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (pcsrc_i),
        .push_i      (rsp_keep),
        .push_data_i (push_entry),
        .pop_i       (pop_fire),
        .head_o      (head_entry),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:  state_d = ST_FETCH;
            ST_FETCH: state_d = ST_FETCH;
            ST_DRAIN: if (discard_q == '0) state_d = ST_FETCH;
            default:  state_d = ST_BOOT;
        endcase
        if (pcsrc_i) state_d = ST_DRAIN;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q <= state_d;
            if (pcsrc_i) begin
                pc_q          <= target_aligned;
                rsp_pc_q      <= target_aligned;
                outstanding_q <= '0;
                discard_q     <= discard_redirect;
            end else begin
                if (req_fire) pc_q <= pc_q + ADDR_WIDTH'(4);
                if (rsp_keep) rsp_pc_q <= rsp_pc_q + ADDR_WIDTH'(4);
                outstanding_q <= outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_keep);
                discard_q     <= discard_q - DISC_W'(rsp_drop);
            end
        end
    end

    // When the buffer empties, decode keeps seeing the last presented entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            held_q <= '0;
        end else if (!fifo_empty) begin
            held_q <= head_entry;
        end
    end

    assign instr_valid_o = !fifo_empty;
    assign instr_o       = fifo_empty ? held_q.instr : head_entry.instr;
    assign pc_o          = fifo_empty ? held_q.pc    : head_entry.pc;

`ifdef FETCH_PERF_EN
    logic [31:0]      fetched_q;
    logic [31:0]      flushed_q;
    logic [SUM_W-1:0] flush_amt;
    logic [32:0]      flushed_sum;

    assign flush_amt   = pcsrc_i ? ({1'b0, fifo_count} + SUM_W'(imem_rvalid_i))
                                 : SUM_W'(rsp_drop);
    assign flushed_sum = {1'b0, flushed_q} + 33'(flush_amt);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetched_q <= '0;
            flushed_q <= '0;
        end else begin
            if (pop_fire && (fetched_q != '1)) fetched_q <= fetched_q + 32'd1;
            flushed_q <= flushed_sum[32] ? '1 : flushed_sum[31:0];
        end
    end

    assign perf_fetched_o = fetched_q;
    assign perf_flushed_o = flushed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model, in-order PC scoreboard and immediate assertions.
// Build with `define FETCH_PERF_EN to also check the performance counters.
`timescale 1ns/1ps
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        pcsrc_i;
    logic [31:0] pc_target_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [1:0]  state_o;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_o;
    logic [31:0] perf_flushed_o;
`endif

    logic [31:0] exp_q[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          cyc, gnt_max, rsp_min, rsp_max;
    int          n_grants, n_accepts, a0;
    int          errors, checks;
    logic        found, saw_wrap;

    fetch_unit #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .pcsrc_i       (pcsrc_i),
        .pc_target_i   (pc_target_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .state_o       (state_o)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched_o (perf_fetched_o),
        .perf_flushed_o (perf_flushed_o)
`endif
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory model: in-order responses, each at least one cycle after its grant.
    task automatic cyc_begin();
        int due;
        @(negedge clk);
        cyc++;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = ~pend_addr[0];
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        if (!rst && imem_req_o && (gnt_max == 0 || $urandom_range(0, gnt_max) == 0)) begin
            imem_gnt_i = 1'b1;
            due = cyc + 1 + int'($urandom_range(rsp_min, rsp_max));
            if (pend_due.size() > 0 && due <= pend_due[$]) due = pend_due[$] + 1;
            pend_addr.push_back(imem_addr_o);
            pend_due.push_back(due);
            n_grants++;
        end
    endtask

    // Scoreboard: each accepted instruction must be the next PC of the current stream.
    task automatic cyc_end();
        logic [31:0] e;
        if (pcsrc_i) begin
            exp_q.delete();
            exp_q.push_back({pc_target_i[31:2], 2'b00});
        end else if (instr_valid_o && instr_ready_i) begin
            n_accepts++;
            e = exp_q.pop_front();
            if (exp_q.size() == 0) exp_q.push_back(e + 32'd4);
            if (e == 32'h0) saw_wrap = 1'b1;
            check("sb_pc", pc_o, e);
            check("sb_instr", instr_o, ~e);
        end
    endtask

    task automatic step(input logic rdy);
        cyc_begin();
        instr_ready_i = rdy;
        pcsrc_i       = 1'b0;
        cyc_end();
    endtask

    task automatic redirect(input logic [31:0] tgt);
        cyc_begin();
        instr_ready_i = 1'b1;
        pcsrc_i       = 1'b1;
        pc_target_i   = tgt;
        cyc_end();
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] exp_pc);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step(1'b1);
            if (instr_valid_o) begin
                found = 1'b1;
                check({tag, "_pc"}, pc_o, exp_pc);
            end
        end
        check({tag, "_seen"}, 32'(found), 32'd1);
    endtask

    initial begin
        errors = 0; checks = 0; cyc = 0; n_grants = 0; n_accepts = 0;
        gnt_max = 0; rsp_min = 0; rsp_max = 0; saw_wrap = 1'b0;
        rst = 1'b1; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        pcsrc_i = 1'b0; pc_target_i = '0; instr_ready_i = 1'b1;
        exp_q.push_back(32'hBFC00000);

        // Reset values
        repeat (3) step(1'b1);
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_addr", imem_addr_o, 32'hBFC00000);
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_pc", pc_o, 32'h0);
        check("rst_state", 32'(state_o), 32'(BOOT));
`ifdef FETCH_PERF_EN
        check("rst_perf_fetched", perf_fetched_o, 32'd0);
        check("rst_perf_flushed", perf_flushed_o, 32'd0);
`endif

        // Reset release: BOOT cycle, then fetch from BFC00000; first valid 3 edges later
        rst = 1'b0;
        check("boot_req", 32'(imem_req_o), 32'd0);
        step(1'b1);
        check("t1_req", 32'(imem_req_o), 32'd1);
        check("t1_addr0", imem_addr_o, 32'hBFC00000);
        check("t1_state", 32'(state_o), 32'(FETCH));
        step(1'b1);
        check("t1_addr1", imem_addr_o, 32'hBFC00004);
        check("t1_valid_early", 32'(instr_valid_o), 32'd0);
        step(1'b1);
        check("t1_first_valid", 32'(instr_valid_o), 32'd1);
        check("t1_first_pc", pc_o, 32'hBFC00000);
        repeat (10) step(1'b1);

        // Back-pressure: buffer fills, requests stop, nothing lost on resume
        repeat (10) step(1'b0);
        check("t2_req_low", 32'(imem_req_o), 32'd0);
        check("t2_valid_held", 32'(instr_valid_o), 32'd1);
        check("t2_head_pc", pc_o, exp_q[0]);
        check("t2_no_pending", 32'(pend_addr.size()), 32'd0);
        a0 = n_accepts;
        repeat (10) step(1'b1);
        check("t2_resumed", 32'(n_accepts > a0), 32'd1);

        // Redirect with two reads in flight on a slow memory
        rsp_min = 3; rsp_max = 3;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cyc_begin();
            instr_ready_i = 1'b1;
            pcsrc_i = (pend_addr.size() == 2);
            pc_target_i = 32'hBFC00040;
            found = pcsrc_i;
            cyc_end();
        end
        check("t3_redirected", 32'(found), 32'd1);
        rsp_min = 0; rsp_max = 0;
        step(1'b1);
        check("t3_valid_n1", 32'(instr_valid_o), 32'd0);
        check("t3_req_n1", 32'(imem_req_o), 32'd1);
        check("t3_addr_n1", imem_addr_o, 32'hBFC00040);
        check("t3_state_drain", 32'(state_o), 32'(DRAIN));
        wait_valid("t3_first", 32'hBFC00040);
        check("t3_state_fetch", 32'(state_o), 32'(FETCH));

        // Redirect coinciding with a grant and a live response on a 1-cycle memory
        repeat (6) step(1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc_begin();
            instr_ready_i = 1'b1;
            pcsrc_i = imem_gnt_i && imem_rvalid_i;
            pc_target_i = 32'hBFC00080;
            found = pcsrc_i;
            cyc_end();
        end
        check("t4_redirected", 32'(found), 32'd1);
        step(1'b1);
        check("t4_valid_n1", 32'(instr_valid_o), 32'd0);
        check("t4_addr_n1", imem_addr_o, 32'hBFC00080);
        step(1'b1);
        check("t4_valid_n2", 32'(instr_valid_o), 32'd0);
        step(1'b1);
        check("t4_valid_n3", 32'(instr_valid_o), 32'd1);
        check("t4_pc_n3", pc_o, 32'hBFC00080);
        repeat (6) step(1'b1);

        // Misaligned target, then back-to-back redirects
        redirect(32'hBFC00043);
        step(1'b1);
        check("t5_aligned_addr", imem_addr_o, 32'hBFC00040);
        wait_valid("t5_aligned", 32'hBFC00040);
        check("t5_aligned_instr", instr_o, ~32'hBFC00040);
        repeat (4) step(1'b1);
        redirect(32'hBFC00100);
        redirect(32'hBFC00200);
        step(1'b1);
        check("t5_b2b_addr", imem_addr_o, 32'hBFC00200);
        wait_valid("t5_b2b", 32'hBFC00200);
        repeat (4) step(1'b1);

        // PC wraps at the top of the address space
        redirect(32'hFFFFFFF8);
        repeat (16) step(1'b1);
        check("wrap_seen", 32'(saw_wrap), 32'd1);

        // Random grant/response latency, back-pressure and redirects
        gnt_max = 2; rsp_min = 0; rsp_max = 5;
        a0 = n_accepts;
        for (int i = 0; i < 300; i++) begin
            cyc_begin();
            instr_ready_i = ($urandom_range(0, 3) != 0);
            pcsrc_i       = ($urandom_range(0, 24) == 0);
            pc_target_i   = 32'hBFC00000 + 32'($urandom_range(0, 1023));
            cyc_end();
        end
        check("rand_progress", 32'(n_accepts - a0 > 10), 32'd1);

        // Quiesce with decode stalled so buffer contents are known
        gnt_max = 0; rsp_min = 0; rsp_max = 0;
        repeat (16) step(1'b0);
        check("end_no_pending", 32'(pend_addr.size()), 32'd0);
        check("end_req_low", 32'(imem_req_o), 32'd0);
        check("end_head_pc", pc_o, exp_q[0]);
`ifdef FETCH_PERF_EN
        check("perf_fetched", perf_fetched_o, 32'(n_accepts));
        check("perf_flushed", perf_flushed_o, 32'(n_grants - n_accepts - int'(DEPTH)));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
